regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the team's 32x32 register file. Adds configurable data width, depth and read-port count.
- Adds optional write-to-read bypass, a per-register pending (scoreboard) bit, and a sequential post-reset clear sweep that replaces the one-cycle bulk reset.
- Sits between decode/issue and writeback in the RV32 core.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (>=2)
ADDR_W, $clog2(NUM_REGS), register address width
NUM_RD, 2, number of combinational read ports (1..4)
BYPASS, 1, 1 = same-cycle writeback forwarded to read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never pending

Ports:
i_clk  input  1  clock, posedge
i_reset  input  1  synchronous, active-high reset
i_rs_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
o_rs_data  output  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
o_rs_pend  output  NUM_RD  pending bit of the addressed register, per port
i_rd_addr  input  ADDR_W  write address
i_rd_data  input  DATA_W  write data
i_rd_wren  input  1  write enable
i_iss_addr  input  ADDR_W  destination being issued (mark pending)
i_iss_valid  input  1  issue strobe
o_ready  output  1  high when the clear sweep has finished and the file is usable

Behaviour:
- Reset: clock is i_clk; reset is synchronous, active-high on i_reset. At an edge with i_reset=1:
  - state <= INIT, sweep counter <= 0, o_ready <= 0.
  - All pending bits <= 0 in that same cycle.
  - Data array is not bulk-reset.
- INIT state:
  - Each cycle writes 0 to entry[counter], then counter++.
  - When counter = NUM_REGS-1 is cleared, the next state is RUN and o_ready=1.
  - Sweep takes exactly NUM_REGS cycles after reset deasserts; o_ready is registered.
- During INIT:
  - i_rd_wren and i_iss_valid are ignored.
  - o_rs_data = 0 and o_rs_pend = 0 on all ports.
- Reset reasserted mid-sweep restarts at counter 0. Reset in RUN re-enters INIT.
- RUN, write:
  - At posedge with i_rd_wren=1 and a valid address, entry[i_rd_addr] <= i_rd_data and pend[i_rd_addr] <= 0.
  - A valid address is < NUM_REGS and not 0 when ZERO_REG=1.
- RUN, issue:
  - At posedge with i_iss_valid=1 and a valid i_iss_addr, pend[i_iss_addr] <= 1.
  - Issue and write to the same address in the same cycle: data is written and pend ends at 1 (the new producer wins).
- Reads are combinational, zero latency: o_rs_data[k] = entry[addr_k], o_rs_pend[k] = pend[addr_k].
- Forced read values:
  - Address 0 with ZERO_REG=1 reads 0, pend 0.
  - Address >= NUM_REGS reads 0, pend 0.
- Bypass (BYPASS=1): if i_rd_wren=1, addr_k = i_rd_addr, and the address is valid, then o_rs_data[k] = i_rd_data and o_rs_pend[k] = 0 in the same cycle.
- BYPASS=0: reads return the old value until the edge.
- All read ports are independent. Multiple ports may read the same address.
- Writes to invalid addresses are dropped silently; no other entry changes.

Test Plan:
- Reset 1 cycle, then release; sample o_ready each cycle -> o_ready=0 for exactly 32 cycles, 1 on cycle 33; all reads 0 throughout, pend=0.
- RUN, write x5=0xDEADBEEF; next cycle read x5 on port0 and x0 on port1 -> 0xDEADBEEF and 0x00000000.
- RUN, write x0=0x1234 with ZERO_REG=1 -> x0 still reads 0.
- BYPASS=1: write x7=0xA5A5A5A5 while port1 reads x7 in the same cycle -> port1 shows 0xA5A5A5A5 combinationally. Repeat with BYPASS=0 -> old value, new value the next cycle.
- Issue x3 -> pend(x3)=1 next cycle. Write x3=0x11 -> pend 0, data 0x11. Issue x3 and write x3=0x22 in the same cycle -> data 0x22, pend 1.
- NUM_REGS=24: write to address 30 -> no entry changes, read of 30 returns 0. Reset asserted at sweep cycle 10 -> o_ready rises 24 cycles after that reset releases.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with per-register pending bits,
// optional write-to-read bypass and a sequential zero-fill sweep after reset.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rs_data,
  output logic [NUM_RD-1:0]          o_rs_pend,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  input  logic [DATA_W-1:0]          i_rd_data,
  input  logic                       i_rd_wren,
  input  logic [ADDR_W-1:0]          i_iss_addr,
  input  logic                       i_iss_valid,
  output logic                       o_ready
);

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;

  logic run;
  logic wr_en;
  logic iss_en;

  // In range, and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run    = (state_q == RUN);
  assign wr_en  = run && i_rd_wren && addr_ok(i_rd_addr);
  assign iss_en = run && i_iss_valid && addr_ok(i_iss_addr);
  assign o_ready = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Storage has no reset; the sweep zero-fills it one entry per cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[i_rd_addr] <= i_rd_data;
      end
    end
  end

  // Issue is applied after writeback so a new producer keeps the bit set.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_q <= '0;
    end else begin
      if (wr_en) begin
        pend_q[i_rd_addr] <= 1'b0;
      end
      if (iss_en) begin
        pend_q[i_iss_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ok;
    logic              byp;

    assign ra  = i_rs_addr[k*ADDR_W +: ADDR_W];
    assign ok  = run && addr_ok(ra);
    assign byp = (BYPASS != 0) && wr_en && (ra == i_rd_addr);

    assign o_rs_data[k*DATA_W +: DATA_W] = !ok ? '0 : (byp ? i_rd_data : mem_q[ra]);
    assign o_rs_pend[k] = ok && !byp && pend_q[ra];
  end

endmodule
